// File: rtl/mips_pkg.sv
// Shared definitions for the multicycle MIPS control path.
// Holds opcode constants, the 4-bit controller state encoding and the
// alusrcb / aluop / pcsource select encodings used by the controller,
// the datapath and the ALU decoder.
package mips_pkg;

    localparam logic [5:0] OP_LB    = 6'b100000;
    localparam logic [5:0] OP_SB    = 6'b101000;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    typedef enum logic [3:0] {
        S_FETCH1  = 4'd0,
        S_FETCH2  = 4'd1,
        S_FETCH3  = 4'd2,
        S_FETCH4  = 4'd3,
        S_DECODE  = 4'd4,
        S_MEMADR  = 4'd5,
        S_LBRD    = 4'd6,
        S_LBWR    = 4'd7,
        S_SBWR    = 4'd8,
        S_RTYPEEX = 4'd9,
        S_RTYPEWR = 4'd10,
        S_BEQEX   = 4'd11,
        S_JEX     = 4'd12,
        S_ADDIEX  = 4'd13,
        S_ADDIWR  = 4'd14,
        S_HALT    = 4'd15
    } state_t;

    // ALU B operand select
    localparam logic [1:0] SRCB_B      = 2'b00;
    localparam logic [1:0] SRCB_ONE    = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_OFFSET = 2'b11;

    // ALU operation class handed to the ALU decoder
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // Next-PC source select
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    function automatic logic is_known_op(input logic [5:0] op);
        return (op == OP_LB) || (op == OP_SB) || (op == OP_RTYPE) ||
               (op == OP_BEQ) || (op == OP_J) || (op == OP_ADDI);
    endfunction

endpackage

// File: rtl/mips_ctrl_decode.sv
// Combinational map from controller state to the raw control word.
// No reset or stall gating happens here; the top applies it.
// Ports:
//   i_state        current (effective) state
//   o_memread .. o_irwrite  raw control outputs for that state
//   o_pcwrite      unconditional PC write request
//   o_pcwritecond  PC write request qualified later by the zero flag
module mips_ctrl_decode
    import mips_pkg::*;
(
    input  logic [3:0] i_state,
    output logic       o_memread,
    output logic       o_memwrite,
    output logic       o_alusrca,
    output logic [1:0] o_alusrcb,
    output logic [1:0] o_aluop,
    output logic       o_memtoreg,
    output logic       o_iord,
    output logic       o_regdst,
    output logic       o_regwrite,
    output logic       o_pcwrite,
    output logic       o_pcwritecond,
    output logic [1:0] o_pcsource,
    output logic [3:0] o_irwrite
);

    always_comb begin
        o_memread     = 1'b0;
        o_memwrite    = 1'b0;
        o_alusrca     = 1'b0;
        o_alusrcb     = SRCB_B;
        o_aluop       = ALUOP_ADD;
        o_memtoreg    = 1'b0;
        o_iord        = 1'b0;
        o_regdst      = 1'b0;
        o_regwrite    = 1'b0;
        o_pcwrite     = 1'b0;
        o_pcwritecond = 1'b0;
        o_pcsource    = PCSRC_ALU;
        o_irwrite     = 4'b0000;
        case (state_t'(i_state))
            S_FETCH1, S_FETCH2, S_FETCH3, S_FETCH4: begin
                o_memread = 1'b1;
                o_alusrcb = SRCB_ONE;
                o_pcwrite = 1'b1;
                // Fetch states are 0..3, so the low two bits pick the IR byte
                o_irwrite = 4'b0001 << i_state[1:0];
            end
            S_DECODE: begin
                o_alusrcb = SRCB_OFFSET;
            end
            S_MEMADR, S_ADDIEX: begin
                o_alusrca = 1'b1;
                o_alusrcb = SRCB_IMM;
            end
            S_LBRD: begin
                o_memread = 1'b1;
                o_iord    = 1'b1;
            end
            S_LBWR: begin
                o_regwrite = 1'b1;
                o_memtoreg = 1'b1;
            end
            S_SBWR: begin
                o_memwrite = 1'b1;
                o_iord     = 1'b1;
            end
            S_RTYPEEX: begin
                o_alusrca = 1'b1;
                o_aluop   = ALUOP_FUNCT;
            end
            S_RTYPEWR: begin
                o_regwrite = 1'b1;
                o_regdst   = 1'b1;
            end
            S_BEQEX: begin
                o_alusrca     = 1'b1;
                o_aluop       = ALUOP_SUB;
                o_pcsource    = PCSRC_ALUOUT;
                o_pcwritecond = 1'b1;
            end
            S_JEX: begin
                o_pcwrite  = 1'b1;
                o_pcsource = PCSRC_JUMP;
            end
            S_ADDIWR: begin
                o_regwrite = 1'b1;
            end
            default: begin
                // HALT: everything stays at its default of 0
            end
        endcase
    end

endmodule

// File: rtl/mips_controller.sv
// Multicycle control FSM for the 8-bit MIPS core. Fetches a 32-bit
// instruction as four bytes, decodes it, and executes it in 1-3 states.
// Ports:
//   clk, reset (sync, active-low), op (IR opcode), zero (ALU flag),
//   stall (hold state, suppress writes);
//   outputs: memory strobes, datapath selects, write enables, pcen,
//   one-hot irwrite, illegal pulse and the debug state.
// Handshake: none; stall is a level that freezes the FSM for as long as
// it is high, and every write-type output is suppressed during that time.
module mips_controller
    import mips_pkg::*;
#(
    parameter int ILLEGAL_TRAP = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic       zero,
    input  logic       stall,
    output logic       memread,
    output logic       memwrite,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] aluop,
    output logic       memtoreg,
    output logic       iord,
    output logic       regdst,
    output logic       regwrite,
    output logic       pcen,
    output logic [1:0] pcsource,
    output logic [3:0] irwrite,
    output logic       illegal,
    output logic [3:0] state
);

    state_t     r_state;
    state_t     w_next_state;
    logic [3:0] w_dec_state;
    logic       w_wr_ok;
    logic       w_memread;
    logic       w_memwrite;
    logic       w_regwrite;
    logic       w_pcwrite;
    logic       w_pcwritecond;
    logic [3:0] w_irwrite;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= S_FETCH1;
        end else if (!stall) begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_FETCH1:  w_next_state = S_FETCH2;
            S_FETCH2:  w_next_state = S_FETCH3;
            S_FETCH3:  w_next_state = S_FETCH4;
            S_FETCH4:  w_next_state = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_LB, OP_SB: w_next_state = S_MEMADR;
                    OP_RTYPE:     w_next_state = S_RTYPEEX;
                    OP_BEQ:       w_next_state = S_BEQEX;
                    OP_J:         w_next_state = S_JEX;
                    OP_ADDI:      w_next_state = S_ADDIEX;
                    default:      w_next_state = (ILLEGAL_TRAP != 0) ? S_HALT : S_FETCH1;
                endcase
            end
            S_MEMADR:  w_next_state = (op == OP_SB) ? S_SBWR : S_LBRD;
            S_LBRD:    w_next_state = S_LBWR;
            S_RTYPEEX: w_next_state = S_RTYPEWR;
            S_ADDIEX:  w_next_state = S_ADDIWR;
            S_LBWR, S_SBWR, S_RTYPEWR, S_BEQEX, S_JEX, S_ADDIWR:
                       w_next_state = S_FETCH1;
            default:   w_next_state = r_state;  // HALT holds until reset
        endcase
    end

    // While reset is held the selects show FETCH1 values regardless of r_state
    assign w_dec_state = reset ? r_state : S_FETCH1;

    mips_ctrl_decode u_decode (
        .i_state       (w_dec_state),
        .o_memread     (w_memread),
        .o_memwrite    (w_memwrite),
        .o_alusrca     (alusrca),
        .o_alusrcb     (alusrcb),
        .o_aluop       (aluop),
        .o_memtoreg    (memtoreg),
        .o_iord        (iord),
        .o_regdst      (regdst),
        .o_regwrite    (w_regwrite),
        .o_pcwrite     (w_pcwrite),
        .o_pcwritecond (w_pcwritecond),
        .o_pcsource    (pcsource),
        .o_irwrite     (w_irwrite)
    );

    // Writes are allowed only out of reset and when not stalled;
    // memread is a read strobe and stays up through a stall.
    assign w_wr_ok  = reset & ~stall;
    assign memread  = w_memread & reset;
    assign memwrite = w_memwrite & w_wr_ok;
    assign regwrite = w_regwrite & w_wr_ok;
    assign pcen     = (w_pcwrite | (w_pcwritecond & zero)) & w_wr_ok;
    assign irwrite  = w_irwrite & {4{w_wr_ok}};
    assign illegal  = (r_state == S_DECODE) & ~is_known_op(op) & w_wr_ok;
    assign state    = r_state;

endmodule
